// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, 3-sample majority
// vote per bit, optional parity, 1 or 2 checked stop bits, and a valid/ready
// holding register with overrun detection.
module uart_rx_param #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX_In,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int MID          = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int IW           = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] T_START    = CW'(MID - 1);
  localparam logic [CW-1:0] T_BIT      = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP  = IW'(STOP_BITS - 1);
  localparam logic          PAR_TARGET = (PARITY == 1);

  if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_rx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done;
  logic                 done_ferr;

  logic                 sync1, rx_s;
  logic [1:0]           hist;
  logic                 vote;
  logic                 load;

  // Synchronise the asynchronous line and keep the two previous samples for the vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      hist  <= '1;
    end else begin
      sync1 <= RX_In;
      rx_s  <= sync1;
      hist  <= {hist[0], rx_s};
    end
  end

  // Majority of the samples taken at T-2, T-1 and T (the current cycle)
  assign vote = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);

  // Frame state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: bit timing, sampling, parity and stop checking
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done      = 1'b0;
    done_ferr = ferr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == T_START) begin
          cnt_d   = '0;
          idx_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          state_d = vote ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == T_BIT) begin
          cnt_d = '0;
          // LSB arrives first: shifting in at the top leaves it at bit 0
          shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == T_BIT) begin
          cnt_d   = '0;
          idx_d   = '0;
          perr_d  = (((^shreg_q) ^ vote) != PAR_TARGET);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == T_BIT) begin
          cnt_d = '0;
          if (!vote) ferr_d = 1'b1;
          if (idx_q == LAST_STOP) begin
            // Finish at the middle of the last stop bit so a following start
            // edge is not missed
            done      = 1'b1;
            done_ferr = ferr_q | ~vote;
            idx_d     = '0;
            state_d   = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign load = done && (!rx_valid || rx_ready);

  // Output holding register with valid/ready handshake and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= done && !load;
      if (load) begin
        rx_data       <= shreg_q;
        rx_parity_err <= perr_q;
        rx_frame_err  <= done_ferr;
        rx_valid      <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid      <= 1'b0;
        rx_parity_err <= 1'b0;
        rx_frame_err  <= 1'b0;
      end
    end
  end

  assign rx_busy = (state_q != S_IDLE);

endmodule
